// File: rtl/ssb_out_ramp_pkg.sv
// Shared encodings and helpers for the SSB DAC output stage and its envelope.
package ssb_pkg;

   localparam logic [1:0] ST_OFF       = 2'd0;
   localparam logic [1:0] ST_RAMP_UP   = 2'd1;
   localparam logic [1:0] ST_ON        = 2'd2;
   localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

   // Unity gain for a GW-bit unsigned envelope: 1.0 = 2^(GW-1).
   function automatic logic [31:0] full_gain(input int gw);
      return 32'd1 << (gw - 1);
   endfunction

   function automatic logic signed [63:0] sat_val(input logic signed [63:0] x, input int ow);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic logic sat_hit(input logic signed [63:0] x, input int ow);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (x > hi) || (x < lo);
   endfunction

endpackage

// File: rtl/ssb_out_ramp_env.sv
// Soft-start/soft-stop amplitude envelope: ramps gain between 0 and unity at ramp_step per clock.
module ssb_env_ramp
   import ssb_pkg::*;
#(
   parameter int GW = 17
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic [GW-1:0] ramp_step,
   output logic [GW-1:0] gain,
   output logic [1:0]    ramp_state
);

   localparam logic [GW:0] FULL = (GW+1)'(full_gain(GW));

   logic [GW:0] cur, stp, sum, g_n;
   logic [1:0]  st_n;

   // Direction follows enable on the same cycle, so a reversal mid-ramp
   // steps from the current gain in the new direction without overshoot.
   always_comb begin
      cur  = {1'b0, gain};
      stp  = {1'b0, ramp_step};
      sum  = cur + stp;
      g_n  = '0;
      st_n = ST_OFF;
      if (enable) begin
         g_n  = (ramp_step == '0 || sum >= FULL) ? FULL : sum;
         st_n = (g_n == FULL) ? ST_ON : ST_RAMP_UP;
      end else begin
         g_n  = (ramp_step == '0 || stp >= cur) ? '0 : cur - stp;
         st_n = (g_n == '0) ? ST_OFF : ST_RAMP_DOWN;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gain       <= '0;
         ramp_state <= ST_OFF;
      end else begin
         gain       <= GW'(g_n);
         ramp_state <= st_n;
      end
   end

endmodule

// File: rtl/ssb_out_ramp.sv
// SSB DAC output stage: I/Q capture, envelope scaling, LO upconversion and
// two samples per clock (direct + midpoint) per DAC channel with saturation.
module ssb_out_ramp
   import ssb_pkg::*;
#(
   parameter int DW = 18,
   parameter int LW = 18,
   parameter int OW = 16,
   parameter int GW = 17
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           div_state,
   input  logic signed [DW-1:0] drive,
   input  logic                 enable,
   input  logic [GW-1:0]        ramp_step,
   input  logic                 ssb_flip,
   input  logic signed [LW-1:0] cosa,
   input  logic signed [LW-1:0] sina,
   input  logic                 sat_clear,
   output logic signed [OW-1:0] dac1_out0,
   output logic signed [OW-1:0] dac1_out1,
   output logic signed [OW-1:0] dac2_out0,
   output logic signed [OW-1:0] dac2_out1,
   output logic [1:0]           ramp_state,
   output logic [GW-1:0]        gain,
   output logic                 sat_flag
);

   localparam int PW = DW + GW + 1;
   localparam int XW = DW + LW;
   localparam int SW = XW + 1;
   localparam int YW = DW + 2;
   localparam int ZW = YW + 1;

   logic signed [DW-1:0] i_reg, q_reg, is_r, qs_r;
   logic signed [LW-1:0] cos_d1, sin_d1, cos_d2, sin_d2;
   logic [2:0]           flip_pipe;
   logic signed [XW-1:0] p_ic, p_qs, p_is, p_qc;
   logic signed [YW-1:0] y1, y2, y1_d, y2_d, y1_n, y2_n, y1_m, y2_m;
   logic                 sat_any;

   ssb_env_ramp #(.GW(GW)) u_env (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .ramp_step  (ramp_step),
      .gain       (gain),
      .ramp_state (ramp_state)
   );

   always_comb begin
      y1_n = YW'((SW'(p_ic) - SW'(p_qs)) >>> (LW - 1));
      y2_n = YW'((SW'(p_is) + SW'(p_qc)) >>> (LW - 1));
      if (flip_pipe[2]) y2_n = -y2_n;
      y1_m = YW'((ZW'(y1) + ZW'(y1_d)) >>> 1);
      y2_m = YW'((ZW'(y2) + ZW'(y2_d)) >>> 1);
      sat_any = sat_hit(64'(y1), OW) | sat_hit(64'(y1_m), OW) |
                sat_hit(64'(y2), OW) | sat_hit(64'(y2_m), OW);
   end

   // LO and flip are registered alongside the I/Q capture so all of them
   // reach the outputs with the same 4-clock latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_reg     <= '0;
         q_reg     <= '0;
         cos_d1    <= '0;
         sin_d1    <= '0;
         cos_d2    <= '0;
         sin_d2    <= '0;
         flip_pipe <= '0;
         is_r      <= '0;
         qs_r      <= '0;
         p_ic      <= '0;
         p_qs      <= '0;
         p_is      <= '0;
         p_qc      <= '0;
         y1        <= '0;
         y2        <= '0;
         y1_d      <= '0;
         y2_d      <= '0;
         dac1_out0 <= '0;
         dac1_out1 <= '0;
         dac2_out0 <= '0;
         dac2_out1 <= '0;
         sat_flag  <= 1'b0;
      end else begin
         case (div_state)
            2'd0, 2'd2: i_reg <= drive;
            default:    q_reg <= drive;
         endcase
         cos_d1    <= cosa;
         sin_d1    <= sina;
         cos_d2    <= cos_d1;
         sin_d2    <= sin_d1;
         flip_pipe <= {flip_pipe[1:0], ssb_flip};
         is_r      <= DW'((PW'(i_reg) * PW'($signed({1'b0, gain}))) >>> (GW - 1));
         qs_r      <= DW'((PW'(q_reg) * PW'($signed({1'b0, gain}))) >>> (GW - 1));
         p_ic      <= XW'(is_r) * XW'(cos_d2);
         p_qs      <= XW'(qs_r) * XW'(sin_d2);
         p_is      <= XW'(is_r) * XW'(sin_d2);
         p_qc      <= XW'(qs_r) * XW'(cos_d2);
         y1        <= y1_n;
         y2        <= y2_n;
         y1_d      <= y1;
         y2_d      <= y2;
         dac1_out0 <= OW'(sat_val(64'(y1), OW));
         dac1_out1 <= OW'(sat_val(64'(y1_m), OW));
         dac2_out0 <= OW'(sat_val(64'(y2), OW));
         dac2_out1 <= OW'(sat_val(64'(y2_m), OW));
         sat_flag  <= sat_any | (sat_flag & ~sat_clear);
      end
   end

endmodule

// File: tb/tb_ssb_out_ramp.sv
// Bench for ssb_out_ramp: directed envelope/tone/saturation/interpolation cases
// and a random run, all scored against a cycle model through a latency queue.
module tb_ssb_out_ramp;

   localparam int DW = 18;
   localparam int LW = 18;
   localparam int OW = 16;
   localparam int GW = 17;
   localparam longint FULL = 65536;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b1;
   logic [1:0]           div_state;
   logic signed [DW-1:0] drive;
   logic                 enable;
   logic [GW-1:0]        ramp_step;
   logic                 ssb_flip;
   logic signed [LW-1:0] cosa, sina;
   logic                 sat_clear;
   logic signed [OW-1:0] dac1_out0, dac1_out1, dac2_out0, dac2_out1;
   logic [1:0]           ramp_state;
   logic [GW-1:0]        gain;
   logic                 sat_flag;

   always #5 clk = ~clk;

   ssb_out_ramp #(.DW(DW), .LW(LW), .OW(OW), .GW(GW)) dut (
      .clk(clk), .reset_n(reset_n), .div_state(div_state), .drive(drive),
      .enable(enable), .ramp_step(ramp_step), .ssb_flip(ssb_flip),
      .cosa(cosa), .sina(sina), .sat_clear(sat_clear),
      .dac1_out0(dac1_out0), .dac1_out1(dac1_out1),
      .dac2_out0(dac2_out0), .dac2_out1(dac2_out1),
      .ramp_state(ramp_state), .gain(gain), .sat_flag(sat_flag)
   );

   typedef struct {
      longint d1o0, d1o1, d2o0, d2o1;
      bit     clip;
   } exp_t;

   exp_t   sbq[$];
   int     n_cmp = 0;
   int     n_err = 0;
   longint tb_i, tb_q;
   longint m_i, m_q, m_g, y1p, y2p;
   int     m_st;
   bit     m_flag;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint tsat(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   task automatic model_init();
      exp_t z;
      z.d1o0 = 0; z.d1o1 = 0; z.d2o0 = 0; z.d2o1 = 0; z.clip = 1'b0;
      sbq.delete();
      repeat (4) sbq.push_back(z);
      m_i = 0; m_q = 0; m_g = 0; m_st = 0; y1p = 0; y2p = 0; m_flag = 1'b0;
   endtask

   // Expected outputs 4 clocks after the current capture state.
   task automatic model_push();
      exp_t   e;
      longint is_v, qs_v, y1, y2, m1, m2;
      is_v = (m_i * m_g) >>> 16;
      qs_v = (m_q * m_g) >>> 16;
      y1 = (is_v * longint'(cosa) - qs_v * longint'(sina)) >>> 17;
      y2 = (is_v * longint'(sina) + qs_v * longint'(cosa)) >>> 17;
      if (ssb_flip) y2 = -y2;
      m1 = (y1 + y1p) >>> 1;
      m2 = (y2 + y2p) >>> 1;
      e.d1o0 = tsat(y1); e.d1o1 = tsat(m1);
      e.d2o0 = tsat(y2); e.d2o1 = tsat(m2);
      e.clip = (e.d1o0 != y1) || (e.d1o1 != m1) || (e.d2o0 != y2) || (e.d2o1 != m2);
      y1p = y1;
      y2p = y2;
      sbq.push_back(e);
   endtask

   task automatic tick();
      exp_t   e;
      longint st;
      drive = div_state[0] ? DW'(tb_q) : DW'(tb_i);
      @(posedge clk);
      #1;
      if (div_state[0]) m_q = longint'(drive); else m_i = longint'(drive);
      st = longint'(ramp_step);
      if (enable) begin
         m_g  = (st == 0 || m_g + st >= FULL) ? FULL : m_g + st;
         m_st = (m_g == FULL) ? 2 : 1;
      end else begin
         m_g  = (st == 0 || st >= m_g) ? 0 : m_g - st;
         m_st = (m_g == 0) ? 0 : 3;
      end
      chk("gain", gain, m_g);
      chk("ramp_state", ramp_state, m_st);
      e = sbq.pop_front();
      m_flag = e.clip || (m_flag && !sat_clear);
      chk("dac1_out0", dac1_out0, e.d1o0);
      chk("dac1_out1", dac1_out1, e.d1o1);
      chk("dac2_out0", dac2_out0, e.d2o0);
      chk("dac2_out1", dac2_out1, e.d2o1);
      chk("sat_flag", sat_flag, m_flag);
      model_push();
      div_state = div_state + 2'd1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   // Asserts reset between edges, so zeroed outputs prove the clear is asynchronous.
   task automatic hold_reset(input int cycles);
      reset_n = 1'b0;
      #1;
      chk("rst_dac1_out0", dac1_out0, 0);
      chk("rst_dac1_out1", dac1_out1, 0);
      chk("rst_dac2_out0", dac2_out0, 0);
      chk("rst_dac2_out1", dac2_out1, 0);
      chk("rst_gain", gain, 0);
      chk("rst_state", ramp_state, 0);
      chk("rst_sat_flag", sat_flag, 0);
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_init();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      div_state = 2'd0; drive = '0; enable = 1'b0; ramp_step = '0; ssb_flip = 1'b0;
      cosa = '0; sina = '0; sat_clear = 1'b0; tb_i = 0; tb_q = 0;
      #2;
      hold_reset(3);

      // unit-LO tone on dac1, then on dac2 with sideband flip
      tb_i = 20000; tb_q = 0; cosa = 18'sd131071; sina = '0; ramp_step = '0; enable = 1'b1;
      run(8);
      chk("tone_d1o0", dac1_out0, 19999);
      chk("tone_d1o1", dac1_out1, 19999);
      chk("tone_d2o0", dac2_out0, 0);
      ssb_flip = 1'b1; run(6);
      chk("tone_flip_d2o0", dac2_out0, 0);
      ssb_flip = 1'b0; cosa = '0; sina = 18'sd131071; run(6);
      chk("sin_d2o0", dac2_out0, 19999);
      ssb_flip = 1'b1; run(6);
      chk("sin_flip_d2o0", dac2_out0, -19999);
      chk("sin_flip_d2o1", dac2_out1, -19999);

      // envelope ramps
      ssb_flip = 1'b0; cosa = 18'sd131071; sina = '0; enable = 1'b0; run(1);
      chk("jump_off", ramp_state, 0);
      ramp_step = 17'd4096; enable = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         run(1);
         chk("up_gain", gain, 4096 * k);
         chk("up_state", ramp_state, (k < 16) ? 1 : 2);
      end
      ramp_step = '0; enable = 1'b0; run(1);
      chk("jump_down_gain", gain, 0);
      ramp_step = 17'd4096; enable = 1'b1; run(8);
      chk("mid_gain", gain, 32768);
      enable = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         run(1);
         chk("down_gain", gain, 32768 - 4096 * k);
         chk("down_state", ramp_state, (k < 8) ? 3 : 0);
      end
      enable = 1'b1; run(8);
      for (int k = 0; k < 10; k++) begin
         enable = (k % 2 == 1);
         run(1);
         chk("toggle_gain", gain, (k % 2 == 0) ? 28672 : 32768);
      end
      chk("pre_rst_state", ramp_state, 1);
      hold_reset(2);
      ramp_step = '0; enable = 1'b1; run(1);
      chk("post_rst_state", ramp_state, 2);
      chk("post_rst_gain", gain, FULL);

      // saturation and sticky flag
      tb_i = 120000; cosa = 18'sd131071; sina = '0; run(8);
      chk("sat_hi", dac1_out0, 32767);
      chk("sat_hi_flag", sat_flag, 1);
      tb_i = -120000; run(8);
      chk("sat_lo", dac1_out0, -32768);
      chk("sat_lo_mid", dac1_out1, -32768);
      sat_clear = 1'b1; run(1); sat_clear = 1'b0;
      chk("sat_set_wins", sat_flag, 1);
      tb_i = 20000; run(8);
      chk("sat_sticky", sat_flag, 1);
      sat_clear = 1'b1; run(1); sat_clear = 1'b0;
      chk("sat_cleared", sat_flag, 0);
      chk("sat_after_d1o0", dac1_out0, 19999);

      // interpolation step through the Q path; sina at negative full scale gives y1 = q exactly
      tb_i = 0; tb_q = 0; cosa = '0; sina = 18'sh20000; run(6);
      chk("interp_pre", dac1_out0, 0);
      if (div_state[0] == 1'b0) run(1);
      tb_q = 16000; run(1);
      for (int k = 1; k <= 5; k++) begin
         run(1);
         chk("interp_out0", dac1_out0, (k < 4) ? 0 : 16000);
         chk("interp_out1", dac1_out1, (k < 4) ? 0 : ((k == 4) ? 8000 : 16000));
      end

      // random traffic
      for (int n = 0; n < 10000; n++) begin
         tb_i = longint'($urandom_range(0, 262143)) - 131072;
         tb_q = longint'($urandom_range(0, 262143)) - 131072;
         if ($urandom_range(0, 1) == 0) begin
            tb_i = tb_i >>> 3;
            tb_q = tb_q >>> 3;
         end
         cosa = LW'($urandom_range(0, 262143));
         sina = LW'($urandom_range(0, 262143));
         if ($urandom_range(0, 15) == 0) enable = ~enable;
         if ($urandom_range(0, 63) == 0) begin
            case ($urandom_range(0, 3))
               0:       ramp_step = '0;
               1:       ramp_step = GW'($urandom_range(1, 512));
               2:       ramp_step = 17'd4096;
               default: ramp_step = GW'($urandom_range(0, 131071));
            endcase
         end
         if ($urandom_range(0, 31) == 0) ssb_flip = ~ssb_flip;
         sat_clear = ($urandom_range(0, 7) == 0);
         run(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ssb_out_ramp.md
Name: ssb_out_ramp

Overview:
Parametrised successor to the single-channel SSB DAC output stage. It takes an interleaved I/Q drive stream and an LO (cos/sin) from rot_dds, applies a soft-start/soft-stop amplitude envelope, and upconverts to two DAC channels. Each DAC channel gets two samples per clock (direct plus interpolated midpoint). The block adds output saturation with a sticky flag and parametrised widths. It sits between the feedback/drive path and the DAC serialisers.

Parameters:
DW, 18, drive input width (signed)
LW, 18, LO cos/sin width (signed, full scale 2^(LW-1)-1)
OW, 16, DAC output width (signed)
GW, 17, envelope gain width (unsigned; FULL = 2^(GW-1) = 1.0)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
div_state  in  2  phase counter; div_state[0]=0 marks I on drive, 1 marks Q
drive  in  DW  interleaved signed I/Q drive
enable  in  1  level; 1 ramps the envelope up, 0 ramps it down
ramp_step  in  GW  gain increment per clock; 0 = instant jump
ssb_flip  in  1  negate the dac2 path (sideband select)
cosa  in  LW  LO cosine
sina  in  LW  LO sine
sat_clear  in  1  clears sat_flag
dac1_out0  out  OW  dac1 sample, direct
dac1_out1  out  OW  dac1 sample, interpolated
dac2_out0  out  OW  dac2 sample, direct
dac2_out1  out  OW  dac2 sample, interpolated
ramp_state  out  2  0=OFF 1=RAMP_UP 2=ON 3=RAMP_DOWN
gain  out  GW  current envelope gain
sat_flag  out  1  sticky; set when any output clips

Behaviour:
- Reset (async, reset_n=0): all outputs 0, ramp_state OFF, gain 0, sat_flag 0, all pipeline registers 0. Release is synchronous to clk.
- Capture:
  - i_reg <= drive when div_state[0]=0.
  - q_reg <= drive when div_state[0]=1.
  - Each register holds otherwise.
- Envelope FSM (updates every clk):
  - OFF: gain=0. enable=1 -> RAMP_UP.
  - RAMP_UP: gain += ramp_step, clamped to FULL. Reaching FULL -> ON. enable=0 -> RAMP_DOWN from the current gain, on the same cycle and with no increment.
  - ON: gain=FULL. enable=0 -> RAMP_DOWN.
  - RAMP_DOWN: gain -= ramp_step, clamped to 0. Reaching 0 -> OFF. enable=1 -> RAMP_UP from the current gain.
  - ramp_step=0: gain jumps straight to FULL (up) or 0 (down), and the FSM lands in ON or OFF in one cycle.
  - Gain arithmetic is GW+1 bits wide before clamping, so it never wraps.
- Datapath (registered stages; truncation is floor / arithmetic shift):
  - S1: Is = (i_reg*gain)>>>(GW-1); Qs = (q_reg*gain)>>>(GW-1). Width DW.
  - S2: products Is*cosa, Qs*sina, Is*sina, Qs*cosa. Width DW+LW.
  - S3:
    - y1 = (Is*cosa - Qs*sina)>>>(LW-1).
    - y2 = (Is*sina + Qs*cosa)>>>(LW-1); negated when ssb_flip=1.
    - Internal width DW+2.
  - S4:
    - out0 = sat(y[n]).
    - out1 = sat((y[n]+y[n-1])>>>1), where y[n-1] is the previous cycle's S3 value.
    - sat() clamps to [-2^(OW-1), 2^(OW-1)-1].
- Latency: 4 clocks from an i_reg/q_reg/cosa/sina change to dac*_out0.
- Saturation flag:
  - sat_flag is set on any clamp in any of the four outputs.
  - It is cleared by sat_clear only.
  - If set and clear occur on the same cycle, set wins.
- ssb_flip and LO inputs take effect with no extra latency beyond the pipeline.
- enable toggling every cycle must not corrupt gain. The FSM alternates RAMP_UP and RAMP_DOWN and gain stays within [0, FULL].

Decomposition:
- Shared package ssb_pkg holds:
  - ramp_state encodings (ST_OFF, ST_RAMP_UP, ST_ON, ST_RAMP_DOWN).
  - FULL gain constant function.
  - Saturation helper function.
- One natural sub-module, ssb_env_ramp: the envelope FSM, producing gain and ramp_state.
- The datapath stays inline.

Test Plan:
Defaults for all scenarios: DW=18, LW=18, OW=16, GW=17, FULL=65536, div_state free-running.
1. Reset mid-RAMP_UP at gain=32768: assert reset_n=0 -> all outputs, gain, sat_flag = 0 immediately (asynchronous). After release with enable=1, step=0 -> ON in 1 cycle.
2. Unit-LO tone:
   - Setup: I=20000, Q=0, cosa=131071, sina=0, step=0, enable=1.
   - Steady state: dac1_out0 = dac1_out1 = 19999; dac2 = 0; with ssb_flip=1, dac2 still 0.
   - Same setup with sina=131071, cosa=0: dac2_out0 = 19999; with ssb_flip=1, -19999.
3. Ramp:
   - step=4096, enable rising -> gain reaches 65536 after exactly 16 cycles, ramp_state 1 then 2.
   - enable drop at gain=32768 -> gain 28672 on the next cycle, reaching OFF 8 cycles after the drop.
4. Saturation:
   - I=120000, cosa=131071 -> dac1_out0 = 32767 and sat_flag=1.
   - I=-120000 -> -32768.
   - sat_clear while saturation persists -> flag stays 1.
   - After drive drops to 20000 and sat_clear -> 0.
5. Interpolation: step y from 0 to 16000 -> dac1_out1 = 8000 for one cycle, then 16000. Latency checked as 4 clocks from the q_reg update.
6. Random: I/Q/LO/enable/step compared against a bit-exact software model over 10000 cycles -> zero mismatches.
